leds_sequencer: RTL

LEDS_SEQUENCER -- requirements
Module: leds_sequencer

---
 rtl/fpga_pkg.sv | 37 +++
 rtl/tick_gen.sv | 35 +++
 rtl/leds_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/fpga_pkg.sv
// fpga_pkg: shared types for the LED display path.
//   binary_data_t : 4-bit pattern driven to the LED decoder (bin2leds)
//   mode_t        : display mode of leds_sequencer
//   shift_dir_t   : travel direction of the lit bit in SHIFT mode
//   next_mode()   : mode sequence STATIC -> COUNT -> SHIFT -> BLINK -> STATIC
package fpga_pkg;

  typedef logic [3:0] binary_data_t;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    COUNT  = 2'd1,
    SHIFT  = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_t;

  // Bounce points of the SHIFT pattern
  localparam binary_data_t SHIFT_MSB = 4'b1000;
  localparam binary_data_t SHIFT_LSB = 4'b0001;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      STATIC:  n = COUNT;
      COUNT:   n = SHIFT;
      SHIFT:   n = BLINK;
      default: n = STATIC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one step strobe every TICK_DIV cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   en   : 1 = count advances, 0 = count holds and tick is suppressed
//   clr  : synchronous clear of the count (restart of a period)
//   tick : high for the whole cycle in which the count equals TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          at_max;

  assign at_max = (count == CNT_MAX);
  // Gated by rst so no strobe is seen while the block is held in reset
  assign tick   = en & ~rst & at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/leds_sequencer.sv
// leds_sequencer: generates the 4-bit LED pattern in one of four modes.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   en          : 1 = prescaler runs, 0 = prescaler and pattern frozen
//   mode_step   : single-cycle pulse, advance to the next display mode
//   sw_data     : switch value shown in STATIC mode
//   binary_data : registered pattern, feeds bin2leds.binary_data
//   mode        : current display mode (FSM state register)
//   tick        : one-cycle strobe marking each pattern step
module leds_sequencer
  import fpga_pkg::*;
#(
  parameter int unsigned TICK_DIV = 27_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode_step,
  input  binary_data_t sw_data,
  output binary_data_t binary_data,
  output mode_t        mode,
  output logic         tick
);

  logic         step_tick;
  shift_dir_t   dir;
  binary_data_t shifted;

  // A mode change restarts the step period
  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (mode_step),
    .tick(step_tick)
  );

  assign tick = step_tick;

  always_comb begin
    shifted = (dir == DIR_LEFT) ? (binary_data << 1) : (binary_data >> 1);
  end

  // mode_step has priority over a coincident tick: the step is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= STATIC;
      binary_data <= '0;
      dir         <= DIR_LEFT;
    end else if (mode_step) begin
      mode <= next_mode(mode);
      dir  <= DIR_LEFT;
      case (next_mode(mode))
        STATIC:  binary_data <= sw_data;
        SHIFT:   binary_data <= SHIFT_LSB;
        default: binary_data <= '0;
      endcase
    end else begin
      case (mode)
        STATIC: binary_data <= sw_data;
        COUNT: begin
          if (step_tick) binary_data <= binary_data + 4'd1;
        end
        SHIFT: begin
          if (step_tick) begin
            binary_data <= shifted;
            // Direction flips on reaching either end of the bar
            if (shifted == SHIFT_MSB) dir <= DIR_RIGHT;
            else if (shifted == SHIFT_LSB) dir <= DIR_LEFT;
          end
        end
        default: begin
          if (step_tick) binary_data <= ~binary_data;
        end
      endcase
    end
  end

endmodule
